// File: rtl/add_sub_seq_pkg.sv
// Shared types for the sequential adder/subtractor: FSM state encoding and
// operation select constants.
package add_sub_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} add_sub_state_t;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

endpackage

// File: rtl/add_sub_seq_if.sv
// Operand/result handshake bundle for add_sub_seq. The v_out/z_out flags only
// exist when ADD_SUB_SEQ_FLAGS_EN is defined.
interface add_sub_seq_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             add;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic             c_out;
`ifdef ADD_SUB_SEQ_FLAGS_EN
  logic             v_out;
  logic             z_out;
`endif

  modport master (
    output in_valid, a, b, add, out_ready,
    input  in_ready, out_valid, q, c_out
`ifdef ADD_SUB_SEQ_FLAGS_EN
    , input v_out, z_out
`endif
  );

  modport slave (
    input  in_valid, a, b, add, out_ready,
    output in_ready, out_valid, q, c_out
`ifdef ADD_SUB_SEQ_FLAGS_EN
    , output v_out, z_out
`endif
  );

endinterface

// File: rtl/add_sub_seq_chunk.sv
// Combinational CHUNK-bit slice adder. c_msb_in is the carry into the slice
// MSB, needed for the signed overflow flag on the top slice.
module add_sub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] sum;

  assign sum      = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
  assign s        = sum[CHUNK-1:0];
  assign cout     = sum[CHUNK];
  // The MSB sum bit is x^y^carry_in, so the carry into it falls out by XOR.
  assign c_msb_in = x[CHUNK-1] ^ y[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/add_sub_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor, one CHUNK-bit slice per cycle with a
// registered carry chain. Define ADD_SUB_SEQ_FLAGS_EN for the v_out/z_out flags.
module add_sub_seq
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  add_sub_seq_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_chunk_check
    $error("add_sub_seq: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  add_sub_state_t state, state_next;
  logic [CW-1:0]                 cnt;
  logic [NCHUNK-1:0][CHUNK-1:0]  a_reg, b_reg, q_reg, q_next;
  logic                          carry, c_reg;
  logic [CHUNK-1:0]              s;
  logic                          cout, c_msb_in;
  logic                          accept, last;

  assign accept = bus.in_valid && (state == IDLE);
  assign last   = (cnt == LAST);

  add_sub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x        (a_reg[cnt]),
    .y        (b_reg[cnt]),
    .cin      (carry),
    .s        (s),
    .cout     (cout),
    .c_msb_in (c_msb_in)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = BUSY;
      BUSY:    if (last)          state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_comb begin
    q_next      = q_reg;
    q_next[cnt] = s;
  end

  // Subtract is a + ~b + 1: invert b at accept and seed the carry with ~add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      q_reg <= '0;
      carry <= 1'b0;
      c_reg <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      a_reg <= bus.a;
      b_reg <= (bus.add == OP_SUB) ? ~bus.b : bus.b;
      carry <= (bus.add == OP_SUB);
      cnt   <= '0;
    end else if (state == BUSY) begin
      q_reg <= q_next;
      carry <= cout;
      if (last) c_reg <= cout;
      else      cnt   <= cnt + 1'b1;
    end
  end

`ifdef ADD_SUB_SEQ_FLAGS_EN
  logic v_reg, z_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_reg <= 1'b0;
      z_reg <= 1'b0;
    end else if (state == BUSY && last) begin
      v_reg <= c_msb_in ^ cout;
      z_reg <= (q_next == '0);
    end
  end

  assign bus.v_out = v_reg;
  assign bus.z_out = z_reg;
`else
  logic flags_unused;
  assign flags_unused = c_msb_in;
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.q         = q_reg;
  assign bus.c_out     = c_reg;

endmodule

// File: tb/tb_add_sub_seq.sv
// Randomized self-checking bench for add_sub_seq (CHUNK=8 and CHUNK=32
// instances) against an arithmetic reference model.
module tb_add_sub_seq;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  typedef struct packed {
    logic [31:0] q;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  add_sub_seq_if #(.WIDTH(WIDTH)) bus   ();
  add_sub_seq_if #(.WIDTH(WIDTH)) bus32 ();

  add_sub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk), .rst_n (rst_n), .bus (bus.slave)
  );

  add_sub_seq #(.WIDTH(WIDTH), .CHUNK(32)) dut32 (
    .clk (clk), .rst_n (rst_n), .bus (bus32.slave)
  );

  // Reference: plain wide integer arithmetic, signed overflow by range check.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic add);
    res_t   r;
    longint ua, ub, sa, sb, us, ss;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    if (add) begin
      us  = ua + ub;
      ss  = sa + sb;
      r.c = (us > 64'hFFFF_FFFF);
    end else begin
      us  = ua - ub;
      ss  = sa - sb;
      r.c = (ua >= ub);
    end
    r.q = us[31:0];
    r.v = (ss > 64'sh7FFF_FFFF) || (ss < -(64'sh8000_0000));
    r.z = (r.q == 32'd0);
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic add,
                          output res_t got, output int lat);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.add = add; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.add = $urandom_range(0, 1);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got.q = bus.q;
    got.c = bus.c_out;
`ifdef ADD_SUB_SEQ_FLAGS_EN
    got.v = bus.v_out;
    got.z = bus.z_out;
`else
    got.v = 1'b0;
    got.z = 1'b0;
`endif
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic start_op32(input logic [31:0] a, input logic [31:0] b, input logic add,
                            output res_t got, output int lat);
    @(negedge clk);
    bus32.a = a; bus32.b = b; bus32.add = add; bus32.in_valid = 1'b1;
    @(negedge clk);
    bus32.in_valid = 1'b0;
    bus32.a = $urandom; bus32.b = $urandom;
    lat = 0;
    while (!bus32.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got.q = bus32.q;
    got.c = bus32.c_out;
`ifdef ADD_SUB_SEQ_FLAGS_EN
    got.v = bus32.v_out;
    got.z = bus32.z_out;
`else
    got.v = 1'b0;
    got.z = 1'b0;
`endif
    bus32.out_ready = 1'b1;
    @(negedge clk);
    bus32.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.q !== 32'd0 || bus.c_out !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b q=%h c=%b, want 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.q, bus.c_out);
    end
    n_vec++;
    if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0 || bus32.q !== 32'd0) begin
      n_miss++;
      $display("[TB] FAIL reset_state32: in_ready=%b out_valid=%b q=%h, want 1 0 0",
               bus32.in_ready, bus32.out_valid, bus32.q);
    end
`ifdef ADD_SUB_SEQ_FLAGS_EN
    n_vec++;
    if (bus.v_out !== 1'b0 || bus.z_out !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL reset_flags: v=%b z=%b, want 0 0", bus.v_out, bus.z_out);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] va [4] = '{32'h0000_0001, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
    logic [31:0] vb [4] = '{32'h0000_0001, 32'h8000_0000, 32'h0000_0001, 32'h0000_0002};
    logic        vop[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] eq [4] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    logic        ec [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic        ev [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic        ez [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    res_t got;
    int   lat;
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i], vop[i], got, lat);
      n_vec++;
      if (lat !== NCHUNK) begin
        n_miss++;
        $display("[TB] FAIL directed%0d_latency: got %0d want %0d", i, lat, NCHUNK);
      end
      n_vec++;
      if (got.q !== eq[i] || got.c !== ec[i]) begin
        n_miss++;
        $display("[TB] FAIL directed%0d_result: q=%h c=%b, want q=%h c=%b", i, got.q, got.c, eq[i], ec[i]);
      end
`ifdef ADD_SUB_SEQ_FLAGS_EN
      n_vec++;
      if (got.v !== ev[i] || got.z !== ez[i]) begin
        n_miss++;
        $display("[TB] FAIL directed%0d_flags: v=%b z=%b, want v=%b z=%b", i, got.v, got.z, ev[i], ez[i]);
      end
`else
      if (ev[i] === 1'bx || ez[i] === 1'bx) $display("[TB] note: unset directed flag %0d", i);
`endif
      finish_op();
    end
  endtask

  task automatic test_random();
    res_t got, exp;
    int   lat;
    logic [31:0] a, b;
    logic add;
    for (int i = 0; i < 24; i++) begin
      a   = pick_operand();
      b   = pick_operand();
      add = $urandom_range(0, 1);
      exp = model(a, b, add);
      start_op(a, b, add, got, lat);
      n_vec++;
      if (lat !== NCHUNK || got.q !== exp.q || got.c !== exp.c) begin
        n_miss++;
        $display("[TB] FAIL random%0d: a=%h b=%h add=%b got q=%h c=%b lat=%0d, want q=%h c=%b lat=%0d",
                 i, a, b, add, got.q, got.c, lat, exp.q, exp.c, NCHUNK);
      end
`ifdef ADD_SUB_SEQ_FLAGS_EN
      n_vec++;
      if (got.v !== exp.v || got.z !== exp.z) begin
        n_miss++;
        $display("[TB] FAIL random%0d_flags: v=%b z=%b, want v=%b z=%b", i, got.v, got.z, exp.v, exp.z);
      end
`endif
      finish_op();
    end
  endtask

  task automatic test_back_to_back();
    res_t got, exp;
    int   lat;
    exp = model(32'h1234_5678, 32'h0FED_CBA9, 1'b0);
    start_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, got, lat);
    n_vec++;
    if (got.q !== exp.q || got.c !== exp.c) begin
      n_miss++;
      $display("[TB] FAIL backpressure_first: q=%h c=%b, want q=%h c=%b", got.q, got.c, exp.q, exp.c);
    end
    // Offer new operands while the result is stalled; they must be ignored.
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.a = $urandom; bus.b = $urandom; bus.add = $urandom_range(0, 1);
      @(negedge clk);
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.q !== exp.q || bus.c_out !== exp.c) begin
        n_miss++;
        $display("[TB] FAIL backpressure_hold%0d: out_valid=%b in_ready=%b q=%h c=%b, want 1 0 %h %b",
                 i, bus.out_valid, bus.in_ready, bus.q, bus.c_out, exp.q, exp.c);
      end
    end
    bus.in_valid = 1'b0;
    finish_op();
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL backpressure_release: in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
    end
    exp = model(32'hDEAD_BEEF, 32'h2152_4111, 1'b1);
    start_op(32'hDEAD_BEEF, 32'h2152_4111, 1'b1, got, lat);
    n_vec++;
    if (lat !== NCHUNK || got.q !== exp.q || got.c !== exp.c) begin
      n_miss++;
      $display("[TB] FAIL backpressure_next: q=%h c=%b lat=%0d, want q=%h c=%b lat=%0d",
               got.q, got.c, lat, exp.q, exp.c, NCHUNK);
    end
    finish_op();
  endtask

  task automatic test_reset_mid_busy();
    res_t got;
    int   lat;
    logic seen;
    @(negedge clk);
    bus.a = 32'h0000_00FF; bus.b = 32'h0000_0001; bus.add = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.q !== 32'd0 || bus.c_out !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_miss++;
      $display("[TB] FAIL reset_mid_busy: q=%h c=%b out_valid=%b in_ready=%b, want 0 0 0 1",
               bus.q, bus.c_out, bus.out_valid, bus.in_ready);
    end
`ifdef ADD_SUB_SEQ_FLAGS_EN
    n_vec++;
    if (bus.v_out !== 1'b0 || bus.z_out !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL reset_mid_busy_flags: v=%b z=%b, want 0 0", bus.v_out, bus.z_out);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL reset_no_pulse: out_valid seen=%b, want 0", seen);
    end
    start_op(32'h0000_00FF, 32'h0000_0001, 1'b1, got, lat);
    n_vec++;
    if (lat !== NCHUNK || got.q !== 32'h0000_0100 || got.c !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL reset_rerun: q=%h c=%b lat=%0d, want 00000100 0 %0d", got.q, got.c, lat, NCHUNK);
    end
    finish_op();
  endtask

  task automatic test_chunk32();
    res_t got, exp;
    int   lat;
    logic [31:0] a, b;
    logic add;
    start_op32(32'h0000_00FF, 32'h0000_0001, 1'b1, got, lat);
    n_vec++;
    if (lat !== 1 || got.q !== 32'h0000_0100 || got.c !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL chunk32_directed: q=%h c=%b lat=%0d, want 00000100 0 1", got.q, got.c, lat);
    end
    for (int i = 0; i < 8; i++) begin
      a   = pick_operand();
      b   = pick_operand();
      add = $urandom_range(0, 1);
      exp = model(a, b, add);
      start_op32(a, b, add, got, lat);
      n_vec++;
      if (lat !== 1 || got.q !== exp.q || got.c !== exp.c) begin
        n_miss++;
        $display("[TB] FAIL chunk32_random%0d: a=%h b=%h add=%b got q=%h c=%b lat=%0d, want q=%h c=%b lat=1",
                 i, a, b, add, got.q, got.c, lat, exp.q, exp.c);
      end
`ifdef ADD_SUB_SEQ_FLAGS_EN
      n_vec++;
      if (got.v !== exp.v || got.z !== exp.z) begin
        n_miss++;
        $display("[TB] FAIL chunk32_flags%0d: v=%b z=%b, want v=%b z=%b", i, got.v, got.z, exp.v, exp.z);
      end
`endif
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0; bus.add = 1'b1;
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b0; bus32.a = '0; bus32.b = '0; bus32.add = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_busy();
    test_chunk32();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
